aes_state_manager: RTL and testbench



---
 rtl/aes_ctrl_pkg.sv | 38 +++
 rtl/aes_state_manager_count4.sv | 33 +++
 rtl/aes_state_manager.sv | 202 ++++++++++++++++++++
 tb/tb_aes_state_manager.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types for the AES-128 control path: FSM states,
// state-matrix write-source codes and the fixed round count.
package aes_ctrl_pkg;

   localparam int NUM_ROUNDS = 10;
   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   typedef enum logic [5:0] {
      ST_IDLE          = 6'd0,
      ST_PTEXT_WRITE   = 6'd1,
      ST_KEY_WRITE     = 6'd2,
      ST_KEY_EXPAND    = 6'd3,
      ST_ADD_KEY0      = 6'd4,
      ST_SUB_BYTES     = 6'd5,
      ST_SHIFT_ROWS    = 6'd6,
      ST_MIX_COLUMNS   = 6'd7,
      ST_ADD_ROUND_KEY = 6'd8,
      ST_DONE          = 6'd9,
      ST_CTEXT_READ    = 6'd10
   } state_e;

   typedef enum logic [3:0] {
      SEL_HOLD  = 4'd0,
      SEL_INPUT = 4'd1,
      SEL_SBOX  = 4'd2,
      SEL_SHIFT = 4'd3,
      SEL_MIX   = 4'd4,
      SEL_ARK   = 4'd5
   } sel_e;

   // States that walk the four columns using the mod-4 counter.
   function automatic logic is_xfer(state_e s);
      return (s == ST_PTEXT_WRITE) ||
             (s == ST_KEY_WRITE)   ||
             (s == ST_CTEXT_READ);
   endfunction

endpackage

// File: rtl/aes_state_manager_count4.sv
// 2-bit mod-4 counter with synchronous clear and enable,
// used to step columns during load and read.
module count4 (
   input  logic       clock,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   output logic [1:0] count
);

   logic [1:0] cnt_q;
   logic [1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 2'd0;
      end else if (en) begin
         cnt_d = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/aes_state_manager.sv
// AES-128 control FSM: load plaintext/key, trigger key expansion,
// sequence ARK0 plus rounds 1..10, then stream ciphertext out.
module aes_state_manager
   import aes_ctrl_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       start_write_n,
   input  logic       start_read_n,
   input  logic       key_expand_done,
   output logic       done,
   output logic [5:0] dbg_state,
   output logic [3:0] dbg_round,
   output logic [3:0] matrix_in_sel,
   output logic       matrix_write_enable,
   output logic       input_mat_row_col,
   output logic [1:0] input_mat_idx,
   output logic       output_mat_row_col,
   output logic [1:0] output_mat_idx,
   output logic       key_start,
   output logic [1:0] count_4_out
);

   state_e     state_q;
   state_e     state_d;
   logic [3:0] round_q;
   logic [3:0] round_d;
   logic       key_start_q;
   logic       key_start_d;

   logic       cnt_clr;
   logic       cnt_en;
   logic [1:0] cnt;
   logic       cnt_last;

   sel_e       sel;
   logic       we;
   logic       done_o;
   logic [1:0] in_idx;
   logic [1:0] out_idx;

   count4 u_count (
      .clock (clock),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (cnt)
   );

   assign cnt_last = (cnt == 2'd3);

   always_comb begin
      cnt_en  = is_xfer(state_q);
      cnt_clr = !cnt_en;
   end

   always_comb begin
      state_d     = state_q;
      round_d     = round_q;
      key_start_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            round_d = 4'd0;
            if (!start_write_n) begin
               state_d = ST_PTEXT_WRITE;
            end
         end
         ST_PTEXT_WRITE: begin
            if (cnt_last) begin
               state_d = ST_KEY_WRITE;
            end
         end
         ST_KEY_WRITE: begin
            // Strobe is registered so it lines up with the first
            // KEY_EXPAND cycle.
            if (cnt_last) begin
               state_d     = ST_KEY_EXPAND;
               key_start_d = 1'b1;
            end
         end
         ST_KEY_EXPAND: begin
            round_d = 4'd0;
            if (key_expand_done) begin
               state_d = ST_ADD_KEY0;
            end
         end
         ST_ADD_KEY0: begin
            state_d = ST_SUB_BYTES;
            round_d = 4'd1;
         end
         ST_SUB_BYTES: begin
            state_d = ST_SHIFT_ROWS;
         end
         ST_SHIFT_ROWS: begin
            if (round_q == LAST_ROUND) begin
               state_d = ST_ADD_ROUND_KEY;
            end else begin
               state_d = ST_MIX_COLUMNS;
            end
         end
         ST_MIX_COLUMNS: begin
            state_d = ST_ADD_ROUND_KEY;
         end
         ST_ADD_ROUND_KEY: begin
            if (round_q == LAST_ROUND) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SUB_BYTES;
               round_d = round_q + 4'd1;
            end
         end
         ST_DONE: begin
            if (!start_read_n) begin
               state_d = ST_CTEXT_READ;
            end
         end
         ST_CTEXT_READ: begin
            if (cnt_last) begin
               state_d = ST_IDLE;
               round_d = 4'd0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            round_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         round_q     <= 4'd0;
         key_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         key_start_q <= key_start_d;
      end
   end

   always_comb begin
      sel     = SEL_HOLD;
      we      = 1'b0;
      done_o  = 1'b0;
      in_idx  = 2'd0;
      out_idx = 2'd0;
      unique case (state_q)
         ST_PTEXT_WRITE: begin
            sel    = SEL_INPUT;
            we     = 1'b1;
            in_idx = cnt;
         end
         ST_KEY_WRITE: begin
            sel    = SEL_INPUT;
            in_idx = cnt;
         end
         ST_ADD_KEY0: begin
            sel = SEL_ARK;
            we  = 1'b1;
         end
         ST_SUB_BYTES: begin
            sel = SEL_SBOX;
            we  = 1'b1;
         end
         ST_SHIFT_ROWS: begin
            sel = SEL_SHIFT;
            we  = 1'b1;
         end
         ST_MIX_COLUMNS: begin
            sel = SEL_MIX;
            we  = 1'b1;
         end
         ST_ADD_ROUND_KEY: begin
            sel = SEL_ARK;
            we  = 1'b1;
         end
         ST_DONE: begin
            done_o = 1'b1;
         end
         ST_CTEXT_READ: begin
            done_o  = 1'b1;
            out_idx = cnt;
         end
         default: begin
         end
      endcase
   end

   assign done                = done_o;
   assign dbg_state           = state_q;
   assign dbg_round           = round_q;
   assign matrix_in_sel       = sel;
   assign matrix_write_enable = we;
   assign input_mat_row_col   = 1'b0;
   assign input_mat_idx       = in_idx;
   assign output_mat_row_col  = 1'b0;
   assign output_mat_idx      = out_idx;
   assign key_start           = key_start_q;
   assign count_4_out         = cnt;

endmodule

// File: tb/tb_aes_state_manager.sv
// Directed/randomized bench for aes_state_manager, checked against
// a per-cycle schedule of expected outputs built from the round rules.
module tb_aes_state_manager;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start_write_n = 1'b1;
   logic       start_read_n = 1'b1;
   logic       key_expand_done = 1'b0;
   logic       done;
   logic [5:0] dbg_state;
   logic [3:0] dbg_round;
   logic [3:0] matrix_in_sel;
   logic       matrix_write_enable;
   logic       input_mat_row_col;
   logic [1:0] input_mat_idx;
   logic       output_mat_row_col;
   logic [1:0] output_mat_idx;
   logic       key_start;
   logic [1:0] count_4_out;

   int passed = 0;
   int total  = 0;

   logic [24:0] obs;
   logic [24:0] enc_q[$];

   aes_state_manager dut (
      .clock               (clock),
      .reset               (reset),
      .start_write_n       (start_write_n),
      .start_read_n        (start_read_n),
      .key_expand_done     (key_expand_done),
      .done                (done),
      .dbg_state           (dbg_state),
      .dbg_round           (dbg_round),
      .matrix_in_sel       (matrix_in_sel),
      .matrix_write_enable (matrix_write_enable),
      .input_mat_row_col   (input_mat_row_col),
      .input_mat_idx       (input_mat_idx),
      .output_mat_row_col  (output_mat_row_col),
      .output_mat_idx      (output_mat_idx),
      .key_start           (key_start),
      .count_4_out         (count_4_out)
   );

   always #5 clock = ~clock;

   assign obs = {dbg_state, dbg_round, matrix_in_sel,
                 matrix_write_enable, input_mat_row_col,
                 input_mat_idx, output_mat_row_col,
                 output_mat_idx, key_start, count_4_out, done};

   function automatic logic [24:0] ev(
      int st, int rnd, int sel, int we, int iidx,
      int oidx, int ks, int cnt, int dn);
      return {6'(st), 4'(rnd), 4'(sel), 1'(we), 1'b0, 2'(iidx),
              1'b0, 2'(oidx), 1'(ks), 2'(cnt), 1'(dn)};
   endfunction

   function automatic logic [24:0] idle_v();
      return ev(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic logic [24:0] done_v();
      return ev(9, 10, 0, 0, 0, 0, 0, 0, 1);
   endfunction

   task automatic chk(input string tag, input logic [24:0] e);
      total++;
      assert (obs === e) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Round schedule: ARK0, then SBOX/SHIFT/MIX/ARK per round,
   // MIX dropped in the last round, then DONE.
   task automatic build_enc();
      enc_q.delete();
      enc_q.push_back(ev(4, 0, 5, 1, 0, 0, 0, 0, 0));
      for (int r = 1; r <= 10; r++) begin
         enc_q.push_back(ev(5, r, 2, 1, 0, 0, 0, 0, 0));
         enc_q.push_back(ev(6, r, 3, 1, 0, 0, 0, 0, 0));
         if (r < 10) enc_q.push_back(ev(7, r, 4, 1, 0, 0, 0, 0, 0));
         enc_q.push_back(ev(8, r, 5, 1, 0, 0, 0, 0, 0));
      end
      enc_q.push_back(done_v());
   endtask

   task automatic do_load(input int both, input int kd_at);
      start_write_n = 1'b0;
      if (both != 0) start_read_n = 1'b0;
      step();
      start_write_n = 1'b1;
      start_read_n  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            if (i == kd_at) key_expand_done = 1'b1;
            step();
            key_expand_done = 1'b0;
         end
         chk("ptext_write", ev(1, 0, 1, 1, i, 0, 0, i, 0));
      end
      for (int i = 0; i < 4; i++) begin
         step();
         chk("key_write", ev(2, 0, 1, 0, i, 0, 0, i, 0));
      end
      step();
      chk("key_start", ev(3, 0, 0, 0, 0, 0, 1, 0, 0));
   endtask

   task automatic do_encrypt(input int wait_n, input int abort_at);
      for (int i = 0; i < wait_n; i++) begin
         step();
         chk("key_wait", ev(3, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      build_enc();
      key_expand_done = 1'b1;
      step();
      key_expand_done = 1'b0;
      for (int i = 0; i <= 40; i++) begin
         if (i > 0) step();
         if (i == abort_at) begin
            #2;
            reset = 1'b1;
            #1;
            chk("async_reset", idle_v());
            return;
         end
         chk($sformatf("enc_%0d", i), enc_q[i]);
      end
   endtask

   task automatic do_read(input int gap);
      for (int i = 0; i < gap; i++) begin
         start_write_n = ($urandom_range(0, 1) == 0);
         step();
         start_write_n = 1'b1;
         chk("done_hold", done_v());
      end
      start_read_n = 1'b0;
      step();
      start_read_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         chk("ctext_read", ev(10, 10, 0, 0, 0, i, 0, i, 1));
      end
      step();
      chk("read_to_idle", idle_v());
   endtask

   initial begin
      #1;
      chk("reset_async", idle_v());
      step();
      chk("reset_c1", idle_v());
      step();
      chk("reset_c2", idle_v());
      reset = 1'b0;
      step();
      chk("idle_after_reset", idle_v());

      for (int t = 0; t < 4; t++) begin
         int gap;
         gap = $urandom_range(1, 4);
         for (int g = 0; g < gap; g++) begin
            start_read_n = 1'b0;
            step();
            start_read_n = 1'b1;
            chk("idle_read_ignored", idle_v());
         end
         do_load((t == 1) ? 1 : 0, (t == 0) ? 2 : $urandom_range(1, 3));
         do_encrypt((t == 0) ? 20 : $urandom_range(0, 12), -1);
         do_read($urandom_range(0, 5));
      end

      do_load(0, 0);
      do_encrypt($urandom_range(0, 5), $urandom_range(2, 38));
      step();
      chk("reset_hold_1", idle_v());
      step();
      chk("reset_hold_2", idle_v());
      reset = 1'b0;
      step();
      chk("idle_after_abort", idle_v());
      do_load(0, 0);
      do_encrypt(1, -1);
      do_read(1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
